ldpc_simd_cnu: RTL
==================

Name: ldpc_simd_cnu

Overview:
- Parametrised, pipelined successor to the ALU's fixed 8x8-bit LDPC lane ops (min, add/sub saturate, add-saturate-min).
- Generalises lane width and count, and saturates symmetrically at both ends.
- Adds a stateful per-lane check-node accumulator (min1/min2/sign-product) for min-sum decoding across several operand beats.
- Sits as an issue-side functional unit beside the ALU, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, datapath width; must be a multiple of Q.
- Q, 8, lane width in bits (two's complement); SIMD = XLEN/Q, derived.
- SAT_MAX, 63, saturation magnitude; results clamp to [-SAT_MAX, +SAT_MAX]; must be <= 2^(Q-1)-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous kill of pending result and accumulator
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept
- op_i  in  3  0 MIN, 1 SUBSAT, 2 ADDSAT, 3 ADDSATMIN, 4 CN_ACC, 5 CN_OUT; 6-7 reserved
- first_i  in  1  CN_ACC: restart accumulation
- operand_a_i  in  XLEN  packed lanes A
- operand_b_i  in  XLEN  packed lanes B
- operand_c_i  in  XLEN  packed lanes C (ADDSATMIN limit)
- valid_o  out  1  result valid
- ready_i  in  1  consumer ready
- result_o  out  XLEN  packed lane results
- acc_valid_o  out  1  accumulator holds at least one CN_ACC beat

Behaviour:
- Accept = valid_i & ready_o; ready_o = ~valid_o | ready_i (single output register, no bubble under continuous ready).
- Latency 1: result registered on the accept edge; valid_o rises the next cycle and holds with result_o stable until valid_o & ready_i.
- Reset: valid_o=0, result_o=0, acc_valid_o=0, every min1/min2 = SAT_MAX, sign-product = 0.
- Lane arithmetic is signed on Q bits with Q+1-bit intermediates. sat(x) = min(max(x, -SAT_MAX), SAT_MAX).
- MIN: lane = (a >= b) ? b : a, unsaturated.
- SUBSAT: lane = sat(a - b).
- ADDSAT: lane = sat(a + b).
- ADDSATMIN: lane = min(sat(a + b), c), signed compare.
- CN_ACC, per lane:
  - m = min(|a|, SAT_MAX); |-2^(Q-1)| saturates.
  - first_i=1 or acc_valid_o=0: min1=m, min2=SAT_MAX, sgn=a[Q-1].
  - Otherwise: if m < min1 then {min2=min1, min1=m}; else if m < min2 then min2=m. sgn ^= a[Q-1].
  - acc_valid_o=1 after the first CN_ACC beat. Result = updated min1 per lane (non-negative).
- CN_OUT, per lane (accumulator unchanged):
  - mag = (min(|a|, SAT_MAX) == min1) ? min2 : min1; s = sgn ^ a[Q-1].
  - Lane = s ? -mag : mag.
  - Equal minima give min2 == min1, so output stays correct.
  - acc_valid_o=0 → reset values are used (mag = SAT_MAX).
- Reserved op: result 0, accumulator untouched, handshake completes normally.
- Accumulator updates only on accept. A stalled output does not block or duplicate the update.
- flush_i has priority over accept in the same cycle:
  - valid_o=0 next cycle; request not accepted.
  - Accumulator reset to reset values; acc_valid_o=0.
- Async reset mid-operation drops the pending result immediately. No partial accumulator state survives.

Test Plan:
- Q=8, SAT_MAX=63, ADDSAT lane0 a=0x30, b=0x20 → 0x3F; lane1 a=0xD0 (-48), b=0xE0 (-32) → 0xC1 (-63); lane2 a=5, b=-3 → 0x02.
- SUBSAT a=0x80, b=0x7F → 0xC1. MIN a=0xFB, b=0x03 → 0xFB. ADDSATMIN a=40, b=10, c=30 → 0x1E (30); c=60 → 0x32 (50).
- CN_ACC all lanes, first_i=1, a=10; then a=-4; then a=7 → results 10, 4, 4; acc_valid_o=1.
  - CN_OUT a=-4 → +7 (0x07); CN_OUT a=10 → -4 (0xFC); CN_OUT a=7 → -4 (0xFC).
- Back-to-back ops with ready_i=1 → one result per cycle, ready_o constantly 1.
  - ready_i held 0 for 3 cycles with a CN_ACC pending → result_o stable, ready_o=0, next CN_ACC accepted only after release, min1 updated exactly once per beat.
- flush_i asserted together with valid_i (CN_ACC a=2) after prior accumulation → no result, acc_valid_o=0; following CN_OUT a=5 → +63 (0x3F).
- rst_ni pulsed low while valid_o=1 → valid_o, result_o, acc_valid_o drop to 0 asynchronously; first post-reset ADDSAT 1+1 → 0x02 per lane.

Source files
------------

// File: rtl/ldpc_simd_cnu.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_simd_cnu
//  Description : SIMD lane unit for min-sum LDPC decoding. Provides lane
//                MIN / SUBSAT / ADDSAT / ADDSATMIN ops with symmetric
//                saturation, plus a per-lane check-node accumulator
//                (min1 / min2 / sign-product) with CN_ACC and CN_OUT ops.
//                Single registered output stage with valid/ready on both
//                sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldpc_simd_cnu #(
    parameter int XLEN    = 64,
    parameter int Q       = 8,
    parameter int SAT_MAX = 63
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic            first_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [XLEN-1:0] operand_c_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            acc_valid_o
);

    localparam int SIMD = XLEN / Q;

    localparam logic [2:0] OP_MIN       = 3'd0;
    localparam logic [2:0] OP_SUBSAT    = 3'd1;
    localparam logic [2:0] OP_ADDSAT    = 3'd2;
    localparam logic [2:0] OP_ADDSATMIN = 3'd3;
    localparam logic [2:0] OP_CN_ACC    = 3'd4;
    localparam logic [2:0] OP_CN_OUT    = 3'd5;

    // Saturation bounds, both on the Q+1-bit intermediate and the Q-bit lane.
    localparam logic signed [Q:0] SAT_P   = (Q+1)'(SAT_MAX);
    localparam logic signed [Q:0] SAT_N   = (Q+1)'(-SAT_MAX);
    localparam logic [Q-1:0]      SAT_P_Q = Q'(SAT_MAX);
    localparam logic [Q-1:0]      SAT_N_Q = Q'(-SAT_MAX);

    logic            accept;
    logic            acc_valid;
    logic            acc_restart;
    logic            acc_update;
    logic [XLEN-1:0] lane_res;

    // Flush wins over a same-cycle request: the request is simply not taken.
    assign ready_o     = ~valid_o | ready_i;
    assign accept      = valid_i & ready_o & ~flush_i;
    assign acc_valid_o = acc_valid;
    assign acc_restart = first_i | ~acc_valid;
    assign acc_update  = accept & (op_i == OP_CN_ACC);

    for (genvar g = 0; g < SIMD; g++) begin : g_lane
        logic [Q-1:0]      a, b, c;
        logic signed [Q:0] ax, bx, cx;
        logic signed [Q:0] sum, diff, sum_sat, a_abs;
        logic [Q-1:0]      m, mag, res;
        logic [Q-1:0]      min1, min2, min1_nx, min2_nx;
        logic              sgn, sgn_nx, s_out;

        assign a  = operand_a_i[g*Q +: Q];
        assign b  = operand_b_i[g*Q +: Q];
        assign c  = operand_c_i[g*Q +: Q];
        assign ax = {a[Q-1], a};
        assign bx = {b[Q-1], b};
        assign cx = {c[Q-1], c};

        // Lane arithmetic, accumulator next-state and lane result selection.
        always_comb begin
            sum     = ax + bx;
            diff    = ax - bx;
            sum_sat = (sum > SAT_P) ? SAT_P : ((sum < SAT_N) ? SAT_N : sum);
            // |a| fits in Q+1 bits even for the most negative code.
            a_abs   = a[Q-1] ? -ax : ax;
            m       = (a_abs > SAT_P) ? SAT_P_Q : a_abs[Q-1:0];

            min1_nx = min1;
            min2_nx = min2;
            sgn_nx  = sgn;
            if (acc_restart) begin
                min1_nx = m;
                min2_nx = SAT_P_Q;
                sgn_nx  = a[Q-1];
            end else begin
                if (m < min1) begin
                    min2_nx = min1;
                    min1_nx = m;
                end else if (m < min2) begin
                    min2_nx = m;
                end
                sgn_nx = sgn ^ a[Q-1];
            end

            // Extrinsic magnitude: exclude this edge's own contribution.
            mag   = (m == min1) ? min2 : min1;
            s_out = sgn ^ a[Q-1];

            res = '0;
            case (op_i)
                OP_MIN:       res = (ax >= bx) ? b : a;
                OP_SUBSAT:    res = (diff > SAT_P) ? SAT_P_Q :
                                    ((diff < SAT_N) ? SAT_N_Q : diff[Q-1:0]);
                OP_ADDSAT:    res = sum_sat[Q-1:0];
                OP_ADDSATMIN: res = (cx < sum_sat) ? c : sum_sat[Q-1:0];
                OP_CN_ACC:    res = min1_nx;
                OP_CN_OUT:    res = s_out ? -mag : mag;
                default:      res = '0;
            endcase
        end

        // Per-lane accumulator state; only an accepted CN_ACC moves it.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                min1 <= SAT_P_Q;
                min2 <= SAT_P_Q;
                sgn  <= 1'b0;
            end else if (flush_i) begin
                min1 <= SAT_P_Q;
                min2 <= SAT_P_Q;
                sgn  <= 1'b0;
            end else if (acc_update) begin
                min1 <= min1_nx;
                min2 <= min2_nx;
                sgn  <= sgn_nx;
            end
        end

        assign lane_res[g*Q +: Q] = res;
    end

    // Accumulator occupancy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_valid <= 1'b0;
        end else if (flush_i) begin
            acc_valid <= 1'b0;
        end else if (acc_update) begin
            acc_valid <= 1'b1;
        end
    end

    // Output register: load on accept, retire on consumer ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o  <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            valid_o  <= 1'b0;
        end else if (accept) begin
            valid_o  <= 1'b1;
            result_o <= lane_res;
        end else if (ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
